// File: rtl/pwm_sorter.sv
// Duty-value holding register bank with a sequential selection sort that fills
// the write slice of the PWM threshold memory rank by rank, then arms a slice swap.
module pwm_sorter #(
    parameter int PWM_WIDTH = 16,
    parameter int NUM_PWM   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       duty_valid,
    output logic                       duty_ready,
    input  logic [$clog2(NUM_PWM)-1:0] duty_chan,
    input  logic [PWM_WIDTH-1:0]       duty_value,
    input  logic                       commit,
    output logic                       busy,
    input  logic                       period_end,
    output logic                       write_enable,
    output logic [$clog2(NUM_PWM)-1:0] waddr,
    output logic [$clog2(NUM_PWM)-1:0] wdata,
    output logic [PWM_WIDTH-1:0]       wthres,
    output logic                       latch_mem
);

    localparam int CHW = $clog2(NUM_PWM);
    localparam logic [CHW-1:0] LAST_IDX = CHW'(NUM_PWM - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        WRITE = 2'd2,
        ARMED = 2'd3
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [PWM_WIDTH-1:0] duty_r [NUM_PWM];
    logic [NUM_PWM-1:0]   taken_r;
    logic [CHW-1:0]       rank_r;
    logic [CHW-1:0]       idx_r;
    logic                 cand_found_r;
    logic [CHW-1:0]       cand_chan_r;
    logic [PWM_WIDTH-1:0] cand_val_r;
    logic                 cand_take_s;
    logic [CHW-1:0]       cand_chan_nxt_s;
    logic [PWM_WIDTH-1:0] cand_val_nxt_s;
    logic                 write_enable_r;
    logic [CHW-1:0]       waddr_r;
    logic [CHW-1:0]       wdata_r;
    logic [PWM_WIDTH-1:0] wthres_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; a commit outside IDLE is simply not looked at.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (commit) begin
                    state_nxt_s = SCAN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SCAN: begin
                if (idx_r == LAST_IDX) begin
                    state_nxt_s = WRITE;
                end else begin
                    state_nxt_s = SCAN;
                end
            end
            WRITE: begin
                if (rank_r == LAST_IDX) begin
                    state_nxt_s = ARMED;
                end else begin
                    state_nxt_s = SCAN;
                end
            end
            ARMED: begin
                if (period_end) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = ARMED;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Running minimum over untaken channels; strict less-than keeps the lowest index on ties.
    always_comb begin
        cand_take_s     = 1'b0;
        cand_chan_nxt_s = cand_chan_r;
        cand_val_nxt_s  = cand_val_r;
        if (!taken_r[idx_r] && (!cand_found_r || (duty_r[idx_r] < cand_val_r))) begin
            cand_take_s     = 1'b1;
            cand_chan_nxt_s = idx_r;
            cand_val_nxt_s  = duty_r[idx_r];
        end else begin
            cand_take_s     = 1'b0;
        end
    end

    // Duty bank, sort bookkeeping and registered memory-write outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PWM; i++) begin
                duty_r[i] <= '0;
            end
            taken_r        <= '0;
            rank_r         <= '0;
            idx_r          <= '0;
            cand_found_r   <= 1'b0;
            cand_chan_r    <= '0;
            cand_val_r     <= '0;
            write_enable_r <= 1'b0;
            waddr_r        <= '0;
            wdata_r        <= '0;
            wthres_r       <= '0;
        end else begin
            write_enable_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (duty_valid && (int'(duty_chan) < NUM_PWM)) begin
                        duty_r[duty_chan] <= duty_value;
                    end
                    if (commit) begin
                        taken_r      <= '0;
                        rank_r       <= '0;
                        idx_r        <= '0;
                        cand_found_r <= 1'b0;
                    end
                end
                SCAN: begin
                    cand_found_r <= cand_found_r | cand_take_s;
                    cand_chan_r  <= cand_chan_nxt_s;
                    cand_val_r   <= cand_val_nxt_s;
                    if (idx_r == LAST_IDX) begin
                        // Launch the write so it is registered during the WRITE cycle.
                        idx_r          <= '0;
                        write_enable_r <= 1'b1;
                        waddr_r        <= rank_r;
                        wdata_r        <= cand_chan_nxt_s;
                        wthres_r       <= cand_val_nxt_s;
                    end else begin
                        idx_r <= idx_r + CHW'(1);
                    end
                end
                WRITE: begin
                    taken_r[wdata_r] <= 1'b1;
                    rank_r           <= rank_r + CHW'(1);
                    cand_found_r     <= 1'b0;
                end
                ARMED: begin
                    cand_found_r <= 1'b0;
                end
                default: begin
                    cand_found_r <= 1'b0;
                end
            endcase
        end
    end

    assign duty_ready   = (state_r == IDLE);
    assign busy         = (state_r != IDLE);
    assign write_enable = write_enable_r;
    assign waddr        = waddr_r;
    assign wdata        = wdata_r;
    assign wthres       = wthres_r;
    // Combinational so the slice swap coincides with the counter wrap edge.
    assign latch_mem    = (state_r == ARMED) & period_end;

endmodule

// File: tb/tb_pwm_sorter.sv
// Directed self-checking bench for pwm_sorter with NUM_PWM=4, PWM_WIDTH=16.
module tb_pwm_sorter;

    localparam int PWM_WIDTH = 16;
    localparam int NUM_PWM   = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 duty_valid;
    logic                 duty_ready;
    logic [1:0]           duty_chan;
    logic [PWM_WIDTH-1:0] duty_value;
    logic                 commit;
    logic                 busy;
    logic                 period_end;
    logic                 write_enable;
    logic [1:0]           waddr;
    logic [1:0]           wdata;
    logic [PWM_WIDTH-1:0] wthres;
    logic                 latch_mem;

    int n_checks = 0;
    int n_errors = 0;
    int exp_ch [4];
    int exp_v  [4];

    pwm_sorter #(.PWM_WIDTH(PWM_WIDTH), .NUM_PWM(NUM_PWM)) dut (
        .clk(clk), .rst_n(rst_n),
        .duty_valid(duty_valid), .duty_ready(duty_ready),
        .duty_chan(duty_chan), .duty_value(duty_value),
        .commit(commit), .busy(busy), .period_end(period_end),
        .write_enable(write_enable), .waddr(waddr), .wdata(wdata),
        .wthres(wthres), .latch_mem(latch_mem)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_duty(input int ch, input int val);
        duty_valid = 1'b1;
        duty_chan  = 2'(ch);
        duty_value = 16'(val);
        tick();
        duty_valid = 1'b0;
    endtask

    task automatic set_exp(input int c0, input int v0, input int c1, input int v1,
                           input int c2, input int v2, input int c3, input int v3);
        exp_ch[0] = c0; exp_v[0] = v0;
        exp_ch[1] = c1; exp_v[1] = v1;
        exp_ch[2] = c2; exp_v[2] = v2;
        exp_ch[3] = c3; exp_v[3] = v3;
    endtask

    // Commit, then walk cycles 1..20 checking every write slot; ends in the first ARMED cycle.
    task automatic run_sort(input bit bp);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        check_eq("busy_after_commit", 32'(busy), 32'd1);
        for (int c = 1; c <= 20; c++) begin
            if (bp && c == 2) begin
                duty_valid = 1'b1;
                duty_chan  = 2'd1;
                duty_value = 16'd1;
                commit     = 1'b1;
                #1;
                check_eq("bp_duty_ready", 32'(duty_ready), 32'd0);
            end
            if (bp && c == 3) begin
                commit = 1'b0;
            end
            check_eq($sformatf("we_c%0d", c), 32'(write_enable), (c % 5 == 0) ? 32'd1 : 32'd0);
            if (c % 5 == 0) begin
                check_eq($sformatf("waddr_r%0d", c / 5 - 1), 32'(waddr), 32'(c / 5 - 1));
                check_eq($sformatf("wdata_r%0d", c / 5 - 1), 32'(wdata), 32'(exp_ch[c / 5 - 1]));
                check_eq($sformatf("wthres_r%0d", c / 5 - 1), 32'(wthres), 32'(exp_v[c / 5 - 1]));
            end
            tick();
        end
        check_eq("armed_busy", 32'(busy), 32'd1);
        check_eq("armed_no_latch", 32'(latch_mem), 32'd0);
    endtask

    task automatic finish_sort();
        period_end = 1'b1;
        #1;
        check_eq("latch_on_period_end", 32'(latch_mem), 32'd1);
        tick();
        period_end = 1'b0;
        check_eq("idle_ready", 32'(duty_ready), 32'd1);
        check_eq("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        duty_valid = 1'b0;
        duty_chan  = 2'd0;
        duty_value = 16'd0;
        commit     = 1'b0;
        period_end = 1'b0;
        tick();
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ready", 32'(duty_ready), 32'd1);
        check_eq("rst_we", 32'(write_enable), 32'd0);
        check_eq("rst_latch", 32'(latch_mem), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic sort with a tie between ch1 and ch3.
        write_duty(0, 300);
        write_duty(1, 100);
        write_duty(2, 200);
        write_duty(3, 100);
        set_exp(1, 100, 3, 100, 2, 200, 0, 300);
        run_sort(1'b0);
        for (int i = 0; i < 50; i++) begin
            check_eq("wait_no_we", 32'(write_enable), 32'd0);
            check_eq("wait_no_latch", 32'(latch_mem), 32'd0);
            tick();
        end
        check_eq("hold_waddr", 32'(waddr), 32'd3);
        check_eq("hold_wdata", 32'(wdata), 32'd0);
        check_eq("hold_wthres", 32'(wthres), 32'd300);
        finish_sort();

        // Duty write and commit in the same cycle; ch2 keeps its new value.
        write_duty(0, 10);
        write_duty(1, 10);
        write_duty(3, 10);
        duty_valid = 1'b1;
        duty_chan  = 2'd2;
        duty_value = 16'd5;
        set_exp(2, 5, 0, 10, 1, 10, 3, 10);
        run_sort(1'b0);
        duty_valid = 1'b0;
        finish_sort();

        // Back-pressure: write and commit during SCAN are held off / ignored.
        set_exp(2, 5, 0, 10, 1, 10, 3, 10);
        run_sort(1'b1);
        check_eq("bp_still_held", 32'(duty_ready), 32'd0);
        finish_sort();
        tick();
        duty_valid = 1'b0;
        set_exp(1, 1, 2, 5, 0, 10, 3, 10);
        run_sort(1'b0);
        finish_sort();

        // Extreme values.
        write_duty(0, 65535);
        write_duty(1, 0);
        write_duty(2, 65535);
        write_duty(3, 0);
        set_exp(1, 0, 3, 0, 0, 65535, 2, 65535);
        run_sort(1'b0);
        finish_sort();

        // Reset in the middle of SCAN.
        commit = 1'b1;
        tick();
        commit = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_ready", 32'(duty_ready), 32'd1);
        check_eq("mid_rst_waddr", 32'(waddr), 32'd0);
        check_eq("mid_rst_wdata", 32'(wdata), 32'd0);
        check_eq("mid_rst_wthres", 32'(wthres), 32'd0);
        tick();
        rst_n      = 1'b1;
        period_end = 1'b1;
        for (int i = 0; i < 25; i++) begin
            tick();
            check_eq("post_rst_no_latch", 32'(latch_mem), 32'd0);
            check_eq("post_rst_no_we", 32'(write_enable), 32'd0);
        end
        period_end = 1'b0;
        set_exp(0, 0, 1, 0, 2, 0, 3, 0);
        run_sort(1'b0);
        finish_sort();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
